// File: rtl/comp_sched_pkg.sv
// Shared types and elaboration helpers for the correction-buffer scheduler.
// Sizes are derived from the antenna count at elaboration time.
package comp_sched_pkg;

    // Ceiling log2, used to size counters from the antenna count and frame length.
    function automatic int log2c(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Number of X-engine taps (including the half-triangle tap k == N/2).
    function automatic int n_taps(input int n_ants);
        return n_ants / 2 + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        READ = 2'd2,
        WAIT = 2'd3
    } sched_state_e;

endpackage

// File: rtl/bl_addr_seq.sv
// Baseline address sequencer: walks antenna a within tap k, in X-engine tap order.
// ant_b wraps modulo N_ANTS because the counter is exactly ANT_BITS wide.
module bl_addr_seq
    import comp_sched_pkg::*;
#(
    parameter int N_ANTS   = 32,
    parameter int ANT_BITS = log2c(N_ANTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic                step,
    output logic [ANT_BITS-1:0] ant_a,
    output logic [ANT_BITS-1:0] ant_b,
    output logic                last,
    output logic                last_tri
);

    localparam logic [ANT_BITS-1:0] A_LAST = ANT_BITS'(N_ANTS - 1);
    localparam logic [ANT_BITS-1:0] K_LAST = ANT_BITS'(N_ANTS / 2);

    logic [ANT_BITS-1:0] a_q, a_d;
    logic [ANT_BITS-1:0] k_q, k_d;

    // NOTE: next-state logic assigns every output a default first, so no path leaves a_d/k_d unassigned and no latch is inferred.
    always_comb begin
        a_d = a_q;
        k_d = k_q;
        if (restart) begin
            a_d = '0;
            k_d = '0;
        end else if (step) begin
            a_d = a_q + ANT_BITS'(1);
            if (a_q == A_LAST) k_d = k_q + ANT_BITS'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            k_q <= '0;
        end else begin
            a_q <= a_d;
            k_q <= k_d;
        end
    end

    assign ant_a    = a_q;
    assign ant_b    = a_q + k_q;
    assign last_tri = (k_q == K_LAST);
    assign last     = last_tri && (a_q == A_LAST);

endmodule

// File: rtl/comp_buf_scheduler.sv
// Double-buffered correction accumulator controller: frame timing, buffer swap,
// baseline readout of the idle buffer, and overrun/resync reporting.
module comp_buf_scheduler
    import comp_sched_pkg::*;
#(
    parameter int N_ANTS              = 32,
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int READ_LATENCY        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sync,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic                       buf_sel,
    output logic [log2c(N_ANTS)-1:0]   ant_a,
    output logic [log2c(N_ANTS)-1:0]   ant_b,
    output logic                       addr_vld,
    output logic                       data_vld,
    output logic                       data_last,
    output logic                       last_triangle,
    output logic                       overrun,
    output logic                       resync_err
);

    localparam int ANT_BITS  = log2c(N_ANTS);
    localparam int FCNT_BITS = ANT_BITS + SERIAL_ACC_LEN_BITS;
    localparam int FRAME_LEN = N_ANTS << SERIAL_ACC_LEN_BITS;

    sched_state_e         state_q, state_d;
    logic [FCNT_BITS-1:0] fcnt_q, fcnt_d;
    logic                 buf_sel_q, buf_sel_d;
    logic                 overrun_q, overrun_d;
    logic                 resync_q, resync_d;
    logic                 frame_end, resync, issue, seq_restart, seq_last, seq_tri, ovr_set;

    logic [READ_LATENCY-1:0] vld_pipe_q, last_pipe_q, tri_pipe_q;

    assign frame_end = (fcnt_q == FCNT_BITS'(FRAME_LEN - 1));
    assign resync    = sync && (state_q != IDLE) && (fcnt_q != '0);
    // A resync aborts the readout on the very cycle it is seen.
    assign issue     = (state_q == READ) && rd_en && !resync;

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        buf_sel_d   = buf_sel_q;
        seq_restart = 1'b0;
        ovr_set     = 1'b0;
        if (state_q != IDLE) fcnt_d = fcnt_q + FCNT_BITS'(1);

        unique case (state_q)
            IDLE: begin
                if (sync) begin
                    fcnt_d  = FCNT_BITS'(1);
                    state_d = FILL;
                end
            end
            FILL, READ, WAIT: begin
                if (resync) begin
                    fcnt_d      = FCNT_BITS'(1);
                    seq_restart = 1'b1;
                    state_d     = FILL;
                end else if (frame_end) begin
                    // A final issue landing on the frame-end cycle still completes the frame.
                    ovr_set     = (state_q == READ) && !(issue && seq_last);
                    buf_sel_d   = !buf_sel_q;
                    seq_restart = 1'b1;
                    state_d     = READ;
                end else if (issue && seq_last) begin
                    state_d = WAIT;
                end
            end
        endcase

        overrun_d = ovr_set || (overrun_q && !clr_err);
        resync_d  = resync;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            buf_sel_q   <= 1'b0;
            overrun_q   <= 1'b0;
            resync_q    <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            tri_pipe_q  <= '0;
        end else begin
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            buf_sel_q      <= buf_sel_d;
            overrun_q      <= overrun_d;
            resync_q       <= resync_d;
            vld_pipe_q[0]  <= issue;
            last_pipe_q[0] <= issue && seq_last;
            tri_pipe_q[0]  <= issue && seq_tri;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
                tri_pipe_q[i]  <= tri_pipe_q[i-1];
            end
        end
    end

    bl_addr_seq #(
        .N_ANTS   (N_ANTS),
        .ANT_BITS (ANT_BITS)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .restart  (seq_restart),
        .step     (issue),
        .ant_a    (ant_a),
        .ant_b    (ant_b),
        .last     (seq_last),
        .last_tri (seq_tri)
    );

    assign buf_sel       = buf_sel_q;
    assign addr_vld      = issue;
    assign data_vld      = vld_pipe_q[READ_LATENCY-1];
    assign data_last     = last_pipe_q[READ_LATENCY-1];
    assign last_triangle = tri_pipe_q[READ_LATENCY-1];
    assign overrun       = overrun_q;
    assign resync_err    = resync_q;

endmodule

// File: tb/tb_comp_buf_scheduler.sv
// Self-checking bench for comp_buf_scheduler (N_ANTS=4, SERIAL_ACC_LEN_BITS=2, READ_LATENCY=2).
// Vector table, directed corner sequences, and randomized traffic against a baseline-index model.
module tb_comp_buf_scheduler;

    localparam int N   = 4;
    localparam int S   = 2;
    localparam int L   = 2;
    localparam int F   = 16;
    localparam int NBL = 12;

    logic       clk = 1'b0;
    logic       rst, sync, rd_en, clr_err;
    logic       buf_sel, addr_vld, data_vld, data_last, last_triangle, overrun, resync_err;
    logic [1:0] ant_a, ant_b;

    always #5 clk = ~clk;

    comp_buf_scheduler #(
        .N_ANTS              (N),
        .SERIAL_ACC_LEN_BITS (S),
        .READ_LATENCY        (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sync          (sync),
        .rd_en         (rd_en),
        .clr_err       (clr_err),
        .buf_sel       (buf_sel),
        .ant_a         (ant_a),
        .ant_b         (ant_b),
        .addr_vld      (addr_vld),
        .data_vld      (data_vld),
        .data_last     (data_last),
        .last_triangle (last_triangle),
        .overrun       (overrun),
        .resync_err    (resync_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: m_n is the index of the next baseline in the frame's readout.
    bit m_synced, m_have, m_buf, m_ovr, m_rerr;
    int m_fcnt, m_n;
    bit pipe_v[$], pipe_l[$], pipe_t[$];
    bit e_vld, e_resync;

    task automatic model_reset();
        m_synced = 0; m_have = 0; m_buf = 0; m_ovr = 0; m_rerr = 0;
        m_fcnt = 0; m_n = 0;
        pipe_v.delete(); pipe_l.delete(); pipe_t.delete();
        for (int i = 0; i < L; i++) begin
            pipe_v.push_back(0); pipe_l.push_back(0); pipe_t.push_back(0);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic c);
        sync = s; rd_en = r; clr_err = c;
    endtask

    task automatic sample();
        @(negedge clk);
        e_resync = sync && m_synced && (m_fcnt != 0);
        e_vld    = m_synced && m_have && (m_n < NBL) && rd_en && !e_resync;
        check("addr_vld", addr_vld, e_vld);
        if (e_vld) begin
            check("ant_a", ant_a, m_n % N);
            check("ant_b", ant_b, ((m_n % N) + (m_n / N)) % N);
        end
        check("data_vld", data_vld, pipe_v[0]);
        check("data_last", data_last, pipe_l[0]);
        check("last_triangle", last_triangle, pipe_t[0]);
        check("buf_sel", buf_sel, m_buf);
        check("overrun", overrun, m_ovr);
        check("resync_err", resync_err, m_rerr);
    endtask

    task automatic advance();
        bit fe, fin, pending, set_o;
        void'(pipe_v.pop_front()); void'(pipe_l.pop_front()); void'(pipe_t.pop_front());
        pipe_v.push_back(e_vld);
        pipe_l.push_back(e_vld && (m_n == NBL - 1));
        pipe_t.push_back(e_vld && ((m_n / N) == N / 2));
        set_o  = 0;
        m_rerr = e_resync;
        if (!m_synced) begin
            if (sync) begin
                m_synced = 1; m_fcnt = 1; m_have = 0;
            end
        end else if (e_resync) begin
            m_fcnt = 1; m_have = 0;
        end else begin
            pending = m_have && (m_n < NBL);
            fin     = e_vld && (m_n == NBL - 1);
            fe      = (m_fcnt == F - 1);
            if (e_vld) m_n++;
            if (fe) begin
                if (pending && !fin) set_o = 1;
                m_buf  = !m_buf;
                m_have = 1;
                m_n    = 0;
            end
            m_fcnt = (m_fcnt + 1) % F;
        end
        if (set_o) m_ovr = 1;
        else if (clr_err) m_ovr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_buf_sel"}, buf_sel, 0);
        check({tag, "_ant_a"}, ant_a, 0);
        check({tag, "_ant_b"}, ant_b, 0);
        check({tag, "_addr_vld"}, addr_vld, 0);
        check({tag, "_data_vld"}, data_vld, 0);
        check({tag, "_data_last"}, data_last, 0);
        check({tag, "_last_tri"}, last_triangle, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_resync_err"}, resync_err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle recording of the directed sequences, checked afterwards at named cycles.
    logic       rec_vld [64];
    logic       rec_dvld[64];
    logic       rec_last[64];
    logic       rec_buf [64];
    logic       rec_ovr [64];
    logic       rec_rerr[64];
    logic [1:0] rec_a   [64];
    logic [1:0] rec_b   [64];

    task automatic run_seq(input int ncyc, input int sync2, input int st_start, input int st_len,
                           input int clr1, input int clr2);
        for (int t = 0; t < ncyc; t++) begin
            drive((t == 0) || (t == sync2), !(t >= st_start && t < st_start + st_len),
                  (t == clr1) || (t == clr2));
            sample();
            rec_vld[t] = addr_vld; rec_dvld[t] = data_vld; rec_last[t] = data_last;
            rec_buf[t] = buf_sel; rec_ovr[t] = overrun; rec_rerr[t] = resync_err;
            rec_a[t] = ant_a; rec_b[t] = ant_b;
            advance();
        end
    endtask

    typedef struct {
        logic       sync;
        logic       rd_en;
        logic       exp_vld;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic       exp_dvld;
        logic       exp_last;
        logic       exp_tri;
        logic       exp_buf;
    } vec_t;

    vec_t vecs[34];
    int   pa[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int   pb[12] = '{0, 1, 2, 3, 1, 2, 3, 0, 2, 3, 0, 1};

    task automatic fill_vectors();
        int idx;
        for (int t = 0; t < 34; t++) begin
            idx = (t >= 32) ? t - 32 : ((t >= 16 && t <= 27) ? t - 16 : 0);
            vecs[t].sync     = (t == 0);
            vecs[t].rd_en    = 1'b1;
            vecs[t].exp_vld  = (t >= 16 && t <= 27) || (t >= 32);
            vecs[t].exp_a    = 2'(pa[idx]);
            vecs[t].exp_b    = 2'(pb[idx]);
            vecs[t].exp_dvld = (t >= 18 && t <= 29);
            vecs[t].exp_last = (t == 29);
            vecs[t].exp_tri  = (t >= 26 && t <= 29);
            vecs[t].exp_buf  = (t >= 16 && t <= 31);
        end
    endtask

    initial begin
        int cnt, thresh;
        fill_vectors();

        // Basic order from the vector table.
        do_reset();
        for (int t = 0; t < 34; t++) begin
            drive(vecs[t].sync, vecs[t].rd_en, 0);
            sample();
            check("tbl_addr_vld", addr_vld, vecs[t].exp_vld);
            if (vecs[t].exp_vld) begin
                check("tbl_ant_a", ant_a, vecs[t].exp_a);
                check("tbl_ant_b", ant_b, vecs[t].exp_b);
            end
            check("tbl_data_vld", data_vld, vecs[t].exp_dvld);
            check("tbl_data_last", data_last, vecs[t].exp_last);
            check("tbl_last_tri", last_triangle, vecs[t].exp_tri);
            check("tbl_buf_sel", buf_sel, vecs[t].exp_buf);
            advance();
        end

        // Four-cycle stall: final issue lands exactly on frame end.
        do_reset();
        run_seq(36, -1, 20, 4, -1, -1);
        cnt = 0;
        for (int t = 16; t < 32; t++) cnt += int'(rec_vld[t]);
        check("stall_issue_count", cnt, NBL);
        check("stall_final_vld", rec_vld[31], 1);
        check("stall_final_a", rec_a[31], 3);
        check("stall_final_b", rec_b[31], 1);
        check("stall_data_last", rec_last[33], 1);
        check("stall_no_overrun", rec_ovr[32], 0);
        check("stall_swap", rec_buf[32], 0);

        // Six-cycle stall: overrun, restart, clear coinciding with set, then clear.
        do_reset();
        run_seq(38, -1, 20, 6, 31, 34);
        check("ovr_before", rec_ovr[31], 0);
        check("ovr_set_wins", rec_ovr[32], 1);
        check("ovr_buf_before", rec_buf[31], 1);
        check("ovr_swap", rec_buf[32], 0);
        check("ovr_restart_vld", rec_vld[32], 1);
        check("ovr_restart_a", rec_a[32], 0);
        check("ovr_restart_b", rec_b[32], 0);
        check("ovr_sticky", rec_ovr[34], 1);
        check("ovr_cleared", rec_ovr[35], 0);
        cnt = 0;
        for (int t = 16; t < 38; t++) cnt += int'(rec_last[t]);
        check("ovr_no_data_last", cnt, 0);

        // Misaligned sync mid-readout.
        do_reset();
        run_seq(40, 20, 99, 0, -1, -1);
        check("rs_no_early_pulse", rec_rerr[20], 0);
        check("rs_pulse", rec_rerr[21], 1);
        check("rs_pulse_single", rec_rerr[22], 0);
        check("rs_abort_vld", rec_vld[20], 0);
        check("rs_stop_vld", rec_vld[21], 0);
        check("rs_buf_hold", rec_buf[21], 1);
        check("rs_buf_hold_late", rec_buf[35], 1);
        check("rs_swap", rec_buf[36], 0);
        check("rs_read_resume", rec_vld[36], 1);

        // Aligned sync is ignored.
        do_reset();
        run_seq(34, 16, 99, 0, -1, -1);
        check("aligned_no_err", rec_rerr[17], 0);
        check("aligned_vld", rec_vld[16], 1);
        check("aligned_swap", rec_buf[32], 0);

        // Asynchronous reset mid-readout.
        do_reset();
        run_seq(22, -1, 99, 0, -1, -1);
        drive(0, 1, 0);
        sample();
        check("rstmid_vld_before", addr_vld, 1);
        #1 rst = 1'b1;
        #1 check_all_zero("rstmid");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            drive(0, 1, 0);
            sample();
            cnt += int'(data_vld) + int'(addr_vld);
            advance();
        end
        check("rstmid_stays_idle", cnt, 0);
        run_seq(20, -1, 99, 0, -1, -1);
        check("rstmid_resync_swap", rec_buf[16], 1);
        check("rstmid_resync_vld", rec_vld[16], 1);

        // Randomized traffic against the model.
        do_reset();
        thresh = 100;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: thresh = 100;
                    1: thresh = 92;
                    default: thresh = 78;
                endcase
            end
            drive((i == 0) || ($urandom_range(0, 299) == 0),
                  $urandom_range(0, 99) < thresh,
                  $urandom_range(0, 39) == 0);
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comp_buf_scheduler.md
Name: comp_buf_scheduler

Overview:
- Controller for the double-buffered correction accumulator in the X-engine correction path.
- Times accumulation frames from `sync` and toggles the write/read buffer select at each frame boundary.
- Generates baseline read addresses (ant_a, ant_b) for the idle buffer in X-engine tap order.
- Flags overruns when a readout does not finish before the next swap, and flags resync events.

Parameters:
- N_ANTS, 32: dual-pol antenna count; power of 2, >=4.
- SERIAL_ACC_LEN_BITS, 7: log2 of the serial accumulation length per antenna.
- READ_LATENCY, 2: clocks from address issue to data valid at the accumulator BRAM output.
- Derived (localparam): ANT_BITS = log2(N_ANTS); N_TAPS = N_ANTS/2+1; FRAME_LEN = N_ANTS<<SERIAL_ACC_LEN_BITS; N_BL = N_ANTS*N_TAPS.
- Legal configurations satisfy N_TAPS <= 2^SERIAL_ACC_LEN_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sync  in  1  single-cycle pulse on the first sample of an accumulation frame
- rd_en  in  1  downstream permits an address issue this cycle
- clr_err  in  1  clears sticky overrun
- buf_sel  out  1  write-buffer select; the read buffer is ~buf_sel
- ant_a  out  ANT_BITS  read address, antenna A
- ant_b  out  ANT_BITS  read address, antenna B
- addr_vld  out  1  ant_a/ant_b issued this cycle
- data_vld  out  1  addr_vld delayed by READ_LATENCY
- data_last  out  1  final baseline of the frame, aligned with data_vld
- last_triangle  out  1  tap index k == N_ANTS/2, aligned with data_vld
- overrun  out  1  sticky error
- resync_err  out  1  single-cycle pulse

Behaviour:
- Reset state: buf_sel=0, ant_a=ant_b=0, all valid/flag outputs 0, frame_cnt=0, state IDLE.
- Reset mid-readout aborts the readout and flushes the delay pipeline to 0.
- IDLE: wait for sync. On sync, frame_cnt<=1 and go to FILL.
- frame_cnt runs 0..FRAME_LEN-1 and wraps. A frame end is the cycle with frame_cnt==FRAME_LEN-1.
- FILL: no buffer is readable yet. At frame end: toggle buf_sel, reset k=0, a=0, go to READ.
- READ: on each cycle with rd_en=1:
  - issue addr_vld=1, ant_a=a, ant_b=(a+k) mod N_ANTS;
  - then a++; when a wraps, k++.
  - The issue with k==N_ANTS/2 and a==N_ANTS-1 is the last; go to WAIT.
  - With rd_en=0, addr_vld=0 and the counters hold.
- WAIT: idle until frame end. At frame end: toggle buf_sel, reset k and a, go to READ.
- Overrun: frame end while in READ with the final issue not made this cycle.
  - Set overrun, abandon the remaining baselines, toggle buf_sel, restart READ at k=0, a=0.
  - A final issue on the frame-end cycle counts as complete; no overrun.
- Resync: sync while frame_cnt != 0 in FILL, READ or WAIT.
  - Pulse resync_err, frame_cnt<=1, no buf_sel toggle, abort the readout, go to FILL.
  - Sync with frame_cnt==0 (aligned) is ignored.
- Delay pipeline: data_vld, data_last and last_triangle are pure READ_LATENCY-stage shift registers of addr_vld, (addr_vld & final issue) and (addr_vld & k==N_ANTS/2). They are not stallable.
- overrun: cleared by clr_err; if set and clear coincide, set wins.
- Per-frame issue count is exactly N_BL unless an abort occurs.

Decomposition:
- Package comp_sched_pkg: log2 function, state encoding (IDLE, FILL, READ, WAIT), ANT_BITS/N_TAPS helper constants.
- One sub-module, bl_addr_seq: the a/k counter pair with modulo ant_b generation and last/last_triangle flags.
  - Inputs: clk, rst, restart, step.
  - Kept separately testable.
- Top level holds the FSM, frame counter and delay pipeline.

Test Plan:
All scenarios use N_ANTS=4, SERIAL_ACC_LEN_BITS=2, READ_LATENCY=2, so FRAME_LEN=16 and N_BL=12.
- Basic order: sync at t0, rd_en=1 throughout.
  - buf_sel toggles at t16.
  - addr_vld t16..t27 with (a,b) = (0,0)(1,1)(2,2)(3,3)(0,1)(1,2)(2,3)(3,0)(0,2)(1,3)(2,0)(3,1).
  - data_vld t18..t29; last_triangle t26..t29; data_last t29 only; next swap t32.
- Stall: rd_en low 4 cycles mid-readout -> identical address sequence, final issue t31, no overrun.
- Overrun: rd_en low 6 cycles -> overrun=1 at t32, buf_sel toggles, readout restarts at (0,0); clr_err -> overrun=0.
- Boundary: rd_en low exactly 4 cycles placed so the final issue lands on frame-end cycle t31 -> overrun stays 0.
- Resync: extra sync at t20 -> resync_err pulse, addr_vld stops, buf_sel unchanged, next swap t36; sync at t16 (aligned) -> no error.
- Async reset asserted at t22 mid-READ -> all outputs 0 immediately, data_vld stays 0 thereafter, state IDLE until next sync.
